// File: rtl/ws2812_driver.sv
// ws2812_driver: serialises a GRB-ordered 24-bit color onto a WS2812 data line; WS2812_AUTO_REFRESH_EN adds resend-on-change
module ws2812_driver #(
  parameter int NUM_LEDS   = 1,
  parameter int T0H_CYC    = 20,
  parameter int T1H_CYC    = 40,
  parameter int TBIT_CYC   = 63,
  parameter int TRESET_CYC = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] cor_in,
  output logic        dout,
  output logic        busy,
  output logic        done
);
  localparam int CMAX = TBIT_CYC > TRESET_CYC ? TBIT_CYC : TRESET_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, thx;
  logic [4:0] bitc, bitc_n;
  logic [9:0] ledc, ledc_n;
  logic [23:0] sh, sh_n, shadow, shadow_n, grb;
  logic go, done_n;
  assign grb = {cor_in[15:8], cor_in[23:16], cor_in[7:0]};
  assign thx = sh[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
`ifdef WS2812_AUTO_REFRESH_EN
  logic [23:0] last;
  logic pend;
  assign go = start | pend | (cor_in != last);
  // Track the last sent color and remember any change seen while a frame is running
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= '0;
      pend <= 1'b0;
    end else if (state == IDLE && go) begin
      last <= cor_in;
      pend <= 1'b0;
    end else if (state != IDLE && cor_in != last) begin
      pend <= 1'b1;
    end
  end
`else
  assign go = start;
`endif
  // Next-state logic: bit high/low phases, word/LED sequencing, latch interval
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    bitc_n   = bitc;
    ledc_n   = ledc;
    sh_n     = sh;
    shadow_n = shadow;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (go) begin
          shadow_n = grb;
          sh_n     = grb;
          bitc_n   = '0;
          ledc_n   = '0;
          state_n  = HIGH;
        end
      end
      HIGH: if (cnt == thx - CW'(1)) begin
        cnt_n   = '0;
        state_n = LOW;
      end
      LOW: if (cnt == CW'(TBIT_CYC) - thx - CW'(1)) begin
        cnt_n = '0;
        if (bitc != 5'd23) begin
          bitc_n  = bitc + 5'd1;
          sh_n    = sh << 1;
          state_n = HIGH;
        end else if (ledc != 10'(NUM_LEDS - 1)) begin
          ledc_n  = ledc + 10'd1;
          bitc_n  = '0;
          sh_n    = shadow;
          state_n = HIGH;
        end else begin
          state_n = LATCH;
        end
      end
      default: if (cnt == CW'(TRESET_CYC - 1)) begin
        cnt_n   = '0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  // State and counters; outputs are registered from the next state so dout is glitch-free
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitc   <= '0;
      ledc   <= '0;
      sh     <= '0;
      shadow <= '0;
      dout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitc   <= bitc_n;
      ledc   <= ledc_n;
      sh     <= sh_n;
      shadow <= shadow_n;
      dout   <= state_n == HIGH;
      busy   <= state_n != IDLE;
      done   <= done_n;
    end
  end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: decodes the dout waveform into bits and checks it against the expected GRB frame
module tb_ws2812_driver;
  localparam int T0 = 2, T1 = 4, TB = 6, TR = 10;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, start1 = 0, start2 = 0;
  logic [23:0] cor1 = 0, cor2 = 0;
  logic dout1, busy1, done1, dout2, busy2, done2;
  int tests = 0, fails = 0, busy_bad = 0;
  bit wave[$];
  bit got;

  ws2812_driver #(.NUM_LEDS(2), .T0H_CYC(T0), .T1H_CYC(T1), .TBIT_CYC(TB), .TRESET_CYC(TR)) u2 (
    .clock(clk), .reset(reset), .start(start2), .cor_in(cor2), .dout(dout2), .busy(busy2), .done(done2));
  ws2812_driver #(.NUM_LEDS(1), .T0H_CYC(T0), .T1H_CYC(T1), .TBIT_CYC(TB), .TRESET_CYC(TR)) u1 (
    .clock(clk), .reset(reset), .start(start1), .cor_in(cor1), .dout(dout1), .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to_grb(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  // Samples dout once per cycle (starting in cycle 1) until done; optionally pokes DUT2 inputs at sample index poke
  task automatic record(input int which, input int poke, input logic [23:0] pval, input bit pstart, output bit got_done);
    wave.delete();
    busy_bad = 0;
    got_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (which == 1 ? done1 : done2) begin
        got_done = 1;
        if (which == 1 ? busy1 : busy2) busy_bad++;
        break;
      end
      wave.push_back(which == 1 ? dout1 : dout2);
      if (!(which == 1 ? busy1 : busy2)) busy_bad++;
      if (i == poke) begin
        cor2 = pval;
        start2 = pstart;
      end
      if (i == poke + 1) start2 = 0;
      @(negedge clk);
    end
  endtask

  // Reference: each bit is a TB-cycle slot, high for T0 (0) or T1 (1) then low; then TR low cycles
  task automatic verify(input string tag, input int n, input logic [23:0] color, input bit got_done);
    logic [23:0] w;
    int h, bad, base;
    bad = 0;
    check({tag, " done"}, 32'(got_done), 1);
    check({tag, " len"}, wave.size(), 24 * n * TB + TR);
    check({tag, " busy"}, busy_bad, 0);
    if (wave.size() == 24 * n * TB + TR) begin
      for (int l = 0; l < n; l++) begin
        w = '0;
        for (int b = 0; b < 24; b++) begin
          base = (l * 24 + b) * TB;
          h = 0;
          while (h < TB && wave[base + h]) h++;
          for (int k = h; k < TB; k++) if (wave[base + k]) bad++;
          if (h != T0 && h != T1) bad++;
          w = {w[22:0], h == T1};
        end
        check({tag, " word"}, w, to_grb(color));
      end
      for (int k = 0; k < TR; k++) if (wave[24 * n * TB + k]) bad++;
      check({tag, " shape"}, bad, 0);
    end
  endtask

  task automatic send2(input logic [23:0] c);
    cor2 = c;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
  endtask

  initial begin
    int cnt;
    logic [23:0] c, pv;
    start2 = 1;
    repeat (3) @(negedge clk);
    check("rst dout", dout2, 0);
    check("rst busy", busy2, 0);
    check("rst done", done2, 0);
    check("rst busy1", busy1, 0);
    reset = 0;
    start2 = 0;
    repeat (3) @(negedge clk);
    check("no frame from reset start", busy2, 0);
`ifndef WS2812_AUTO_REFRESH_EN
    send2(24'hFF0055);
    record(2, -1, 0, 0, got);
    verify("encode", 2, 24'hFF0055, got);
    @(negedge clk);
    check("done single", done2, 0);
    check("busy after", busy2, 0);
    send2(24'hFF0055);
    record(2, 100, 24'h123456, 1, got);
    verify("isolate", 2, 24'hFF0055, got);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy2 || done2) cnt++;
    end
    check("isolate no refire", cnt, 0);
    send2(24'hFF0055);
    repeat (10 * TB) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst dout", dout2, 0);
    check("midrst busy", busy2, 0);
    check("midrst done", done2, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done2 || busy2) cnt++;
    end
    check("midrst no done", cnt, 0);
    for (int r = 0; r < 4; r++) begin
      c = 24'($urandom);
      send2(c);
      record(2, -1, 0, 0, got);
      verify("random", 2, c, got);
      @(negedge clk);
    end
    cor1 = 24'h000000;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    record(1, -1, 0, 0, got);
    verify("n1 zero", 1, 24'h000000, got);
    @(negedge clk);
    c = 24'($urandom);
    cor1 = c;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    check("b2b accept", busy1, 1);
    record(1, -1, 0, 0, got);
    verify("b2b", 1, c, got);
`else
    cor2 = 24'h0000FF;
    @(negedge clk);
    for (int i = 0; i < 5 && !busy2; i++) @(negedge clk);
    check("auto start", busy2, 1);
    pv = 24'($urandom) | 24'h000100;
    record(2, 60, pv, 0, got);
    verify("auto first", 2, 24'h0000FF, got);
    @(negedge clk);
    for (int i = 0; i < 5 && !busy2; i++) @(negedge clk);
    check("auto pending", busy2, 1);
    record(2, -1, 0, 0, got);
    verify("auto second", 2, pv, got);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy2) cnt++;
    end
    check("auto quiet", cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
